// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - frame-buffer address generator and RGB444->RGB888 DAC front end
//
// Sits after the 640x480@60 timing generator. Walks the 320x240 frame buffer
// sequentially while activeArea is high, hides the buffer read latency, widens
// RGB444 to RGB888 and delays sync/blank so every DAC input stays aligned.
//
// Ports:
//   CLK25         pixel clock
//   rst           synchronous reset, active-high
//   hsync_i       timing-generator Hsync (active-low)
//   vsync_i       timing-generator Vsync (active-low)
//   nblank_i      1 inside the visible 640x480 area
//   active_i      1 inside the 320x240 frame-buffer window
//   rd_addr_o     frame-buffer read address
//   rd_data_i     RGB444 read data, RD_LAT cycles after its address
//   r_o/g_o/b_o   RGB888 to the DAC
//   hsync_o       hsync_i delayed RD_LAT+1 cycles
//   vsync_o       vsync_i delayed RD_LAT+1 cycles
//   nblank_o      nblank_i delayed RD_LAT+1 cycles
//   frame_start_o one-cycle pulse after a vsync_i falling edge
//   overrun_o     sticky: the window asked for more than PIXELS pixels this frame

module vga_pixel_fetch #(
    parameter int          PIXELS     = 76800,
    parameter int          AW         = 17,
    parameter int          RD_LAT     = 2,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic          CLK25,
    input  logic          rst,
    input  logic          hsync_i,
    input  logic          vsync_i,
    input  logic          nblank_i,
    input  logic          active_i,
    output logic [AW-1:0] rd_addr_o,
    input  logic [11:0]   rd_data_i,
    output logic [7:0]    r_o,
    output logic [7:0]    g_o,
    output logic [7:0]    b_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          nblank_o,
    output logic          frame_start_o,
    output logic          overrun_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

    logic              vsync_prev;
    logic              wrapped;       // a full frame's worth of pixels has been fetched
    logic [RD_LAT-1:0] a_d;           // active_i aligned to rd_data_i
    logic [RD_LAT-1:0] n_d;           // nblank_i aligned to rd_data_i
    logic [RD_LAT:0]   hs_d;
    logic [RD_LAT:0]   vs_d;
    logic [RD_LAT:0]   nb_d;
    logic              frame_start;

    assign frame_start = vsync_prev & ~vsync_i;

    // Address counter, frame-start detection and overrun tracking.
    always_ff @(posedge CLK25) begin
        if (rst) begin
            rd_addr_o     <= '0;
            vsync_prev    <= 1'b1;
            frame_start_o <= 1'b0;
            overrun_o     <= 1'b0;
            wrapped       <= 1'b0;
        end else begin
            vsync_prev    <= vsync_i;
            frame_start_o <= frame_start;
            if (frame_start) begin
                rd_addr_o <= '0;
                overrun_o <= 1'b0;
                wrapped   <= 1'b0;
            end else if (active_i) begin
                // The wrap itself consumes the last legal pixel; only a
                // request after it is an overrun.
                if (wrapped) begin
                    overrun_o <= 1'b1;
                end
                if (rd_addr_o == LAST_ADDR) begin
                    rd_addr_o <= '0;
                    wrapped   <= 1'b1;
                end else begin
                    rd_addr_o <= rd_addr_o + AW'(1);
                end
            end
        end
    end

    // Delay lines and RGB output register.
    always_ff @(posedge CLK25) begin
        if (rst) begin
            a_d  <= '0;
            n_d  <= '0;
            hs_d <= '1;
            vs_d <= '1;
            nb_d <= '0;
            r_o  <= 8'h00;
            g_o  <= 8'h00;
            b_o  <= 8'h00;
        end else begin
            a_d[0]  <= active_i;
            n_d[0]  <= nblank_i;
            for (int i = 1; i < RD_LAT; i++) begin
                a_d[i] <= a_d[i-1];
                n_d[i] <= n_d[i-1];
            end
            hs_d[0] <= hsync_i;
            vs_d[0] <= vsync_i;
            nb_d[0] <= nblank_i;
            for (int i = 1; i <= RD_LAT; i++) begin
                hs_d[i] <= hs_d[i-1];
                vs_d[i] <= vs_d[i-1];
                nb_d[i] <= nb_d[i-1];
            end
            if (!n_d[RD_LAT-1]) begin
                r_o <= 8'h00;
                g_o <= 8'h00;
                b_o <= 8'h00;
            end else if (!a_d[RD_LAT-1]) begin
                r_o <= BORDER_RGB[23:16];
                g_o <= BORDER_RGB[15:8];
                b_o <= BORDER_RGB[7:0];
            end else begin
                // Nibble replication maps 0..F onto the full 0..FF range.
                r_o <= {rd_data_i[11:8], rd_data_i[11:8]};
                g_o <= {rd_data_i[7:4],  rd_data_i[7:4]};
                b_o <= {rd_data_i[3:0],  rd_data_i[3:0]};
            end
        end
    end

    assign hsync_o  = hs_d[RD_LAT];
    assign vsync_o  = vs_d[RD_LAT];
    assign nblank_o = nb_d[RD_LAT];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - self-checking bench for vga_pixel_fetch

module tb_vga_pixel_fetch;

    localparam int          PIXELS = 76800;
    localparam int          AW     = 17;
    localparam int          RD_LAT = 2;
    localparam int          D      = RD_LAT + 1;
    localparam logic [23:0] BORDER = 24'h102030;

    logic          CLK25 = 1'b0;
    logic          rst = 1'b1;
    logic          hsync_i = 1'b1;
    logic          vsync_i = 1'b1;
    logic          nblank_i = 1'b0;
    logic          active_i = 1'b0;
    logic [AW-1:0] rd_addr_o;
    logic [11:0]   rd_data_i = 12'h000;
    logic [7:0]    r_o, g_o, b_o;
    logic          hsync_o, vsync_o, nblank_o, frame_start_o, overrun_o;

    vga_pixel_fetch #(
        .PIXELS(PIXELS), .AW(AW), .RD_LAT(RD_LAT), .BORDER_RGB(BORDER)
    ) dut (
        .CLK25(CLK25), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .nblank_i(nblank_i), .active_i(active_i), .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .nblank_o(nblank_o),
        .frame_start_o(frame_start_o), .overrun_o(overrun_o)
    );

    always #20 CLK25 = ~CLK25;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame-buffer contents seen by the bench.
    function automatic logic [11:0] ram(input logic [AW-1:0] a);
        case (a)
            17'd0:   return 12'hF80;
            17'd1:   return 12'h08F;
            17'd2:   return 12'h000;
            17'd3:   return 12'hFFF;
            default: return 12'((a * 37) ^ (a >> 3));
        endcase
    endfunction

    function automatic logic [23:0] expand(input logic [11:0] p);
        return {8'(p[11:8] * 17), 8'(p[7:4] * 17), 8'(p[3:0] * 17)};
    endfunction

    // Eight-cycle input history, indexed by cycle number mod 8.
    bit            hh[8], hv[8], hn[8], ha[8];
    int            maddr[8];
    logic [AW-1:0] daddr[8];
    int            cyc = 8;
    int            pix = 0;   // pixels requested since frame start / reset

    task automatic set_idle(input int s);
        hh[s] = 1'b1; hv[s] = 1'b1; hn[s] = 1'b0; ha[s] = 1'b0;
    endtask

    task automatic check_cycle();
        int s3;
        logic [23:0] exp_rgb;
        s3 = (cyc - D) & 7;
        if (!hn[s3])      exp_rgb = 24'h000000;
        else if (!ha[s3]) exp_rgb = BORDER;
        else              exp_rgb = expand(ram(AW'(maddr[s3])));
        chk("rd_addr", 32'(rd_addr_o), 32'(pix % PIXELS));
        chk("overrun", 32'(overrun_o), 32'(pix > PIXELS));
        chk("frame_start", 32'(frame_start_o), 32'(hv[(cyc-2)&7] & ~hv[(cyc-1)&7]));
        chk("hsync_o", 32'(hsync_o), 32'(hh[s3]));
        chk("vsync_o", 32'(vsync_o), 32'(hv[s3]));
        chk("nblank_o", 32'(nblank_o), 32'(hn[s3]));
        chk("rgb", 32'({r_o, g_o, b_o}), 32'(exp_rgb));
    endtask

    // Drive one cycle of inputs, let the edge happen, then check against the model.
    task automatic tick(input logic h, input logic v, input logic n, input logic a, input logic r);
        int s;
        s = cyc & 7;
        hsync_i = h; vsync_i = v; nblank_i = n; active_i = a; rst = r;
        daddr[s]  = rd_addr_o;
        rd_data_i = ram(daddr[(cyc - RD_LAT) & 7]);
        hh[s] = h; hv[s] = v; hn[s] = n; ha[s] = a;
        maddr[s] = pix % PIXELS;
        if (r) begin
            for (int k = 0; k < D; k++) set_idle((cyc - k) & 7);
        end
        @(posedge CLK25);
        #1;
        if (r)                           pix = 0;
        else if (hv[(cyc-1)&7] && !v)    pix = 0;
        else if (a)                      pix++;
        cyc++;
        check_cycle();
    endtask

    logic [23:0] rgb_seen[4];
    int          low_cnt, first_low;

    initial begin
        for (int i = 0; i < 8; i++) begin
            set_idle(i);
            maddr[i] = 0;
            daddr[i] = '0;
        end
        @(negedge CLK25);

        // 1: reset held three cycles with idle inputs
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 1);
        chk("t1_rgb", 32'({r_o, g_o, b_o}), 32'h0);
        chk("t1_syncs", 32'({hsync_o, vsync_o, nblank_o}), 32'b110);
        chk("t1_addr", 32'(rd_addr_o), 32'd0);
        for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 0);
        chk("t1_fs", 32'(frame_start_o), 32'd0);

        // 2: four window pixels from address 0
        for (int i = 1; i <= 7; i++) begin
            if (i <= 4) tick(1, 1, 1, 1, 0);
            else        tick(1, 1, 0, 0, 0);
            if (i >= 3 && i <= 6) rgb_seen[i-3] = {r_o, g_o, b_o};
        end
        chk("t2_px0", 32'(rgb_seen[0]), 32'hFF8800);
        chk("t2_px1", 32'(rgb_seen[1]), 32'h0088FF);
        chk("t2_px2", 32'(rgb_seen[2]), 32'h000000);
        chk("t2_px3", 32'(rgb_seen[3]), 32'hFFFFFF);

        // 3: 96-cycle hsync pulse while blanked
        low_cnt = 0; first_low = -1;
        for (int i = 1; i <= 104; i++) begin
            tick(i <= 96 ? 1'b0 : 1'b1, 1, 0, 0, 0);
            if (!hsync_o) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
        end
        chk("t3_low_len", 32'(low_cnt), 32'd96);
        chk("t3_first_low", 32'(first_low), 32'd3);

        // 4: visible border, address held
        for (int i = 0; i < 5; i++) tick(1, 1, 1, 0, 0);
        chk("t4_rgb", 32'({r_o, g_o, b_o}), 32'(BORDER));
        chk("t4_addr", 32'(rd_addr_o), 32'd4);

        // 5: vsync falls together with an active cycle at address 500
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) tick(1, 1, 1, 1, 0);
        chk("t5_addr500", 32'(rd_addr_o), 32'd500);
        tick(1, 0, 1, 1, 0);
        chk("t5_addr0", 32'(rd_addr_o), 32'd0);
        chk("t5_fs", 32'(frame_start_o), 32'd1);
        tick(1, 1, 0, 0, 0);
        chk("t5_fs_end", 32'(frame_start_o), 32'd0);

        // 6: exactly one frame of pixels, then one more
        tick(1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < PIXELS; i++) tick(1, 1, 1, 1, 0);
        chk("t6_addr", 32'(rd_addr_o), 32'd0);
        chk("t6_no_overrun", 32'(overrun_o), 32'd0);
        tick(1, 1, 1, 1, 0);
        chk("t6_overrun", 32'(overrun_o), 32'd1);
        for (int i = 0; i < 20; i++) tick(1, 1, 0, 0, 0);
        chk("t6_sticky", 32'(overrun_o), 32'd1);
        tick(1, 0, 0, 0, 0);
        chk("t6_cleared", 32'(overrun_o), 32'd0);

        // Random traffic with one reset in the middle
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 9) != 0,
                 $urandom_range(0, 199) != 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom),
                 i == 700);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
